// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider:
//   - state_t     : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - CLA_SLICE   : bit width of one carry-lookahead slice
//   - cla_pad_width() : rounds a width up to a whole number of CLA slices
// ---------------------------------------------------------------------------
package seq_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int CLA_SLICE = 4;

   function automatic int cla_pad_width(input int n);
      return ((n + CLA_SLICE - 1) / CLA_SLICE) * CLA_SLICE;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
//   Request/result bundle of the divider (start/busy/done handshake).
//   master : requester side - drives start, dividend, divisor;
//            receives busy, done, quotient, remainder, div_by_zero
//   slave  : divider side   - the mirror image
// ---------------------------------------------------------------------------
interface seq_divider_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider_cla_sub_n.sv
// ---------------------------------------------------------------------------
// cla_sub_n
//   N-bit subtractor diff = a - b built as a + ~b + 1 on chained 4-bit
//   carry-lookahead slices (lookahead inside a slice, ripple between slices).
//   Ports:
//     a, b      in  N  operands (unsigned)
//     diff      out N  a - b modulo 2^N
//     carry_out out 1  carry out of bit N-1; 1 means no borrow (a >= b)
//   The operands are padded up to a whole number of slices; the padding
//   bits produce sum/carry values that are deliberately discarded.
// ---------------------------------------------------------------------------
module cla_sub_n
   import seq_divider_pkg::*;
#(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         carry_out
);
   localparam int NP = cla_pad_width(N);
   localparam int NS = NP / CLA_SLICE;

   logic [NP-1:0] a_pad;
   logic [NP-1:0] b_inv;
   logic [NP-1:0] g;
   logic [NP-1:0] p;
   logic [NP-1:0] sum;
   logic [NP:0]   c;

   assign a_pad = NP'(a);
   assign b_inv = ~(NP'(b));
   assign g     = a_pad & b_inv;
   assign p     = a_pad ^ b_inv;
   assign c[0]  = 1'b1;           // +1 completes the two's complement of b

   genvar gi;
   generate
      for (gi = 0; gi < NS; gi++) begin : g_slice
         localparam int B = gi * CLA_SLICE;
         logic c0;
         assign c0 = c[B];
         // Every carry of the slice is derived directly from the slice carry-in.
         assign c[B+1] = g[B] | (p[B] & c0);
         assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c0);
         assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                       | (p[B+2] & p[B+1] & p[B] & c0);
         assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B])
                       | (p[B+3] & p[B+2] & p[B+1] & p[B] & c0);
      end
   endgenerate

   assign sum       = p ^ c[NP-1:0];
   assign diff      = sum[N-1:0];
   assign carry_out = c[N];

   // Padding bits carry no information.
   logic unused_pad;
   assign unused_pad = ^{sum[NP-1:N], c[NP:N+1]};
endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Unsigned sequential restoring divider, one quotient bit per cycle.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  synchronous reset, active-low
//     bus    seq_divider_if.slave:
//              start/dividend/divisor in, busy/done/quotient/remainder/
//              div_by_zero out
//   Timing: accept at edge k -> busy cycles k+1..k+WIDTH -> done in k+WIDTH+1.
//   A zero divisor skips the iterations and completes in cycle k+1.
// ---------------------------------------------------------------------------
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_divider_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             dbz_reg;

   logic             accept;
   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   r_trial;
   logic [WIDTH:0]   r_step;
   logic [WIDTH-1:0] q_step;
   logic             no_borrow;

   // ---------------- restoring step ----------------
   assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

   cla_sub_n #(.N(WIDTH + 1)) u_sub (
      .a         (r_shift),
      .b         ({1'b0, divisor_reg}),
      .diff      (r_trial),
      .carry_out (no_borrow)
   );

   assign r_step = no_borrow ? r_trial : r_shift;
   assign q_step = {q_reg[WIDTH-2:0], no_borrow};
   assign accept = (state_reg == ST_IDLE) && bus.start;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (bus.start) state_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
         ST_RUN:  if (cnt_reg == '0) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // Results are written on the edge that enters DONE, so they are already
   // on the outputs during the done pulse and stay there until the next op.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_reg         <= '0;
         q_reg         <= '0;
         divisor_reg   <= '0;
         cnt_reg       <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else if (accept) begin
         r_reg       <= '0;
         q_reg       <= bus.dividend;
         divisor_reg <= bus.divisor;
         cnt_reg     <= CW'(WIDTH - 1);
         dbz_reg     <= (bus.divisor == '0);
         if (bus.divisor == '0) begin
            quotient_reg  <= '1;
            remainder_reg <= bus.dividend;
         end
      end else if (state_reg == ST_RUN) begin
         r_reg <= r_step;
         q_reg <= q_step;
         if (cnt_reg == '0) begin
            quotient_reg  <= q_step;
            remainder_reg <= r_step[WIDTH-1:0];
         end else begin
            cnt_reg <= cnt_reg - CW'(1);
         end
      end
   end

   assign bus.busy        = (state_reg == ST_RUN);
   assign bus.done        = (state_reg == ST_DONE);
   assign bus.quotient    = quotient_reg;
   assign bus.remainder   = remainder_reg;
   assign bus.div_by_zero = dbz_reg;

   // The partial remainder never exceeds the divisor, so its MSB is shifted out unseen.
   logic unused_msb;
   assign unused_msb = r_reg[WIDTH];
endmodule
